// File: rtl/tensor_stream_flattener.sv
// Buffers one W x H x C tensor and streams it LANES elements per beat,
// in either storage order or channel-major order.
module tensor_stream_flattener #(
    parameter int WIDTH     = 4,
    parameter int HEIGHT    = 4,
    parameter int CHANNEL   = 3,
    parameter int DATA_SIZE = 16,
    parameter int LANES     = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [WIDTH*HEIGHT*CHANNEL*DATA_SIZE-1:0]     s_data,
    input  logic                                          s_order,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [LANES*DATA_SIZE-1:0]                    m_data,
    output logic                                          m_last,
    output logic [$clog2(WIDTH*HEIGHT*CHANNEL)-1:0]       m_index
);

    localparam int N  = WIDTH * HEIGHT * CHANNEL;
    localparam int IW = $clog2(N);
    localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

    localparam logic [WW-1:0] W_MAX  = WW'(WIDTH - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HEIGHT - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HEIGHT - LANES);
    localparam logic [HW-1:0] H_STEP = HW'(LANES);
    localparam logic [CW-1:0] C_MAX  = CW'(CHANNEL - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNEL - LANES);
    localparam logic [CW-1:0] C_STEP = CW'(LANES);
    localparam logic          ONE_BEAT = (N == LANES);

    if ((HEIGHT % LANES) != 0 || (CHANNEL % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide both HEIGHT and CHANNEL");
    end

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state_q, state_d;

    logic [DATA_SIZE-1:0] buf_q [N];
    logic                 order_q;
    logic [WW-1:0]        w_q, w_d;
    logic [HW-1:0]        h_q, h_d;
    logic [CW-1:0]        c_q, c_d;
    logic                 out_hs;
    logic                 take;
    logic                 last_next;

    logic [LANES*DATA_SIZE-1:0] first_data;
    logic [LANES*DATA_SIZE-1:0] next_data;

    assign m_valid = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        out_hs  = m_valid && m_ready;
        s_ready = (state_q == IDLE) || (out_hs && m_last);
        take    = s_valid && s_ready;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = STREAM;
            STREAM:  if (out_hs && m_last && !s_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Innermost counter steps by LANES; outer counters step by one.
    always_comb begin
        w_d = w_q;
        h_d = h_q;
        c_d = c_q;
        if (!order_q) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                if (h_q == H_MAX) begin
                    h_d = '0;
                    w_d = w_q + WW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end else begin
                c_d = c_q + C_STEP;
            end
        end else begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (w_q == W_MAX) begin
                    w_d = '0;
                    c_d = c_q + CW'(1);
                end else begin
                    w_d = w_q + WW'(1);
                end
            end else begin
                h_d = h_q + H_STEP;
            end
        end
        last_next = order_q ? (c_d == C_MAX && w_d == W_MAX && h_d == H_LAST)
                            : (w_d == W_MAX && h_d == H_MAX && c_d == C_LAST);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0] idx;
        assign first_data[l*DATA_SIZE +: DATA_SIZE] = s_order
            ? s_data[l*CHANNEL*DATA_SIZE +: DATA_SIZE]
            : s_data[l*DATA_SIZE +: DATA_SIZE];
        assign idx = order_q
            ? IW'((int'(w_d) * HEIGHT + int'(h_d) + l) * CHANNEL + int'(c_d))
            : IW'((int'(w_d) * HEIGHT + int'(h_d)) * CHANNEL + int'(c_d) + l);
        assign next_data[l*DATA_SIZE +: DATA_SIZE] = buf_q[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            order_q <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_index <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                order_q <= s_order;
                w_q     <= '0;
                h_q     <= '0;
                c_q     <= '0;
                m_data  <= first_data;
                m_last  <= ONE_BEAT;
                m_index <= '0;
            end else if (out_hs) begin
                if (m_last) begin
                    m_last <= 1'b0;
                end else begin
                    w_q     <= w_d;
                    h_q     <= h_d;
                    c_q     <= c_d;
                    m_data  <= next_data;
                    m_last  <= last_next;
                    m_index <= m_index + IW'(LANES);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            for (int e = 0; e < N; e++) begin
                buf_q[e] <= s_data[e*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_tensor_stream_flattener.sv
// Bench for tensor_stream_flattener: order reference built from nested
// dimension loops, checked beat by beat on two parameterisations.
module tb_tensor_stream_flattener;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int C  = 3;
    localparam int DS = 16;
    localparam int N  = W * H * C;

    localparam int BW = 2;
    localparam int BH = 4;
    localparam int BC = 2;
    localparam int BL = 2;
    localparam int BN = BW * BH * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            s_valid, s_ready, s_order;
    logic [N*DS-1:0] s_data;
    logic            m_valid, m_ready, m_last;
    logic [DS-1:0]   m_data;
    logic [5:0]      m_index;

    logic              b_s_valid, b_s_ready, b_s_order;
    logic [BN*DS-1:0]  b_s_data;
    logic              b_m_valid, b_m_ready, b_m_last;
    logic [BL*DS-1:0]  b_m_data;
    logic [3:0]        b_m_index;

    tensor_stream_flattener dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_order(s_order),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_index(m_index)
    );

    tensor_stream_flattener #(
        .WIDTH(BW), .HEIGHT(BH), .CHANNEL(BC), .DATA_SIZE(DS), .LANES(BL)
    ) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_order(b_s_order),
        .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_last(b_m_last), .m_index(b_m_index)
    );

    int passed = 0;
    int total  = 0;

    logic [DS-1:0] cur [N];
    logic [DS-1:0] nxt [N];
    int            exp_e[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output order straight from the nesting rules.
    task automatic make_seq(input int wd, input int hd, input int cd,
                            input bit ord);
        exp_e.delete();
        if (!ord) begin
            for (int w = 0; w < wd; w++)
                for (int h = 0; h < hd; h++)
                    for (int c = 0; c < cd; c++)
                        exp_e.push_back((w * hd + h) * cd + c);
        end else begin
            for (int c = 0; c < cd; c++)
                for (int w = 0; w < wd; w++)
                    for (int h = 0; h < hd; h++)
                        exp_e.push_back((w * hd + h) * cd + c);
        end
    endtask

    task automatic load_a(input bit use_nxt);
        for (int e = 0; e < N; e++)
            s_data[e*DS +: DS] = use_nxt ? nxt[e] : cur[e];
    endtask

    task automatic accept_a(input bit ord);
        s_valid = 1'b1;
        s_order = ord;
        load_a(1'b0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int e = 0; e < N; e++) s_data[e*DS +: DS] = DS'($urandom);
    endtask

    task automatic stream_a(input bit ord, input bit rnd, input bit preload,
                            input bit nord, input int abort_at);
        int b   = 0;
        int cyc = 0;
        make_seq(W, H, C, ord);
        while (b < N && cyc < 1000) begin
            if (b == abort_at) begin
                rst     = 1'b1;
                m_ready = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_m_valid", m_valid, 0);
                chk("abort_s_ready", s_ready, 1);
                chk("abort_m_last", m_last, 0);
                return;
            end
            if (preload && cyc == 9) begin
                s_valid = 1'b1;
                s_order = nord;
                load_a(1'b1);
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("m_valid", m_valid, 1);
            chk("m_data", m_data, cur[exp_e[b]]);
            chk("m_index", m_index, b);
            chk("m_last", m_last, b == N - 1);
            chk("s_ready", s_ready, m_ready && b == N - 1);
            if (m_valid && m_ready) b++;
            @(posedge clk); #1;
            cyc++;
        end
        if (preload) s_valid = 1'b0;
        chk("beat_count", b, N);
    endtask

    task automatic check_idle_a();
        m_ready = 1'b1;
        #1;
        chk("idle_m_valid", m_valid, 0);
        chk("idle_s_ready", s_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BL*DS-1:0] bexp;
        bit               rord;

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_order   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        b_s_valid = 1'b0;
        b_s_order = 1'b0;
        b_s_data  = '0;
        b_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_b_m_valid", b_m_valid, 0);
        rst = 1'b0;

        for (int e = 0; e < N; e++) cur[e] = DS'(e);
        accept_a(1'b0);
        stream_a(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_idle_a();

        accept_a(1'b1);
        stream_a(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check_idle_a();

        accept_a(1'b0);
        stream_a(1'b0, 1'b1, 1'b0, 1'b0, -1);
        check_idle_a();

        for (int e = 0; e < N; e++) nxt[e] = DS'(e + 100);
        accept_a(1'b0);
        stream_a(1'b0, 1'b0, 1'b1, 1'b0, -1);
        for (int e = 0; e < N; e++) cur[e] = nxt[e];
        stream_a(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_idle_a();

        for (int e = 0; e < N; e++) cur[e] = DS'(e);
        accept_a(1'b0);
        stream_a(1'b0, 1'b0, 1'b0, 1'b0, 20);
        accept_a(1'b0);
        stream_a(1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_idle_a();

        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < N; e++) cur[e] = DS'($urandom);
            rord = 1'($urandom_range(0, 1));
            accept_a(rord);
            stream_a(rord, 1'b1, 1'b0, 1'b0, -1);
            check_idle_a();
        end

        for (int ord = 0; ord < 2; ord++) begin
            for (int e = 0; e < BN; e++) b_s_data[e*DS +: DS] = DS'(e);
            b_s_valid = 1'b1;
            b_s_order = 1'(ord);
            @(posedge clk); #1;
            b_s_valid = 1'b0;
            make_seq(BW, BH, BC, 1'(ord));
            for (int k = 0; k < BN / BL; k++) begin
                for (int l = 0; l < BL; l++)
                    bexp[l*DS +: DS] = DS'(exp_e[k*BL + l]);
                chk("b_m_valid", b_m_valid, 1);
                chk("b_m_data", b_m_data, bexp);
                chk("b_m_index", b_m_index, k * BL);
                chk("b_m_last", b_m_last, k == BN / BL - 1);
                @(posedge clk); #1;
            end
            chk("b_idle_m_valid", b_m_valid, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tensor_stream_flattener.md
# tensor_stream_flattener

Sequential successor to the combinational flatten functions. It accepts one complete W×H×C activation tensor as a flat bus, holds it in a single internal buffer, and streams it out LANES elements per beat over a valid/ready interface. The output order is selectable per tensor. It sits between a convolution/pooling stage that produces a whole feature map and the fully-connected stage that consumes a serial flattened vector.

## Interface
- WIDTH, 4: tensor dimension w (outermost in storage)
- HEIGHT, 4: tensor dimension h
- CHANNEL, 3: tensor dimension c (innermost in storage)
- DATA_SIZE, 16: bits per element
- LANES, 1: elements per output beat; must divide both HEIGHT and CHANNEL (elaboration error otherwise)
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input tensor valid
- s_ready  out  1  input tensor accepted when s_valid && s_ready
- s_data  in  WIDTH*HEIGHT*CHANNEL*DATA_SIZE  flat tensor; element (w,h,c) at bits [e*DATA_SIZE +: DATA_SIZE], e = (w*HEIGHT+h)*CHANNEL+c
- s_order  in  1  0 = storage order (c fastest, then h, then w); 1 = channel-major (h fastest, then w, then c); sampled with s_data
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat consumed when m_valid && m_ready
- m_data  out  LANES*DATA_SIZE  lane l at [l*DATA_SIZE +: DATA_SIZE], lane 0 = earliest element in output order
- m_last  out  1  high on the final beat of a tensor
- m_index  out  clog2(W*H*C)  output-sequence index of lane 0 (0, LANES, 2·LANES, …)

## Operation
- FSM states are IDLE and STREAM. Reset enters IDLE.
- IDLE: s_ready=1 and m_valid=0. On s_valid, latch s_data and s_order, clear the counters (w,h,c) to 0, and go to STREAM.
- STREAM: m_valid=1. m_data is the buffer elements at the current (w,h,c) plus the next LANES-1 elements along the innermost dimension of the latched order.
- Order 0: counters nest c (step LANES) inside h inside w.
- Order 1: counters nest h (step LANES) inside w inside c.
- Counters and m_index advance only on an output handshake.
- Total beats per tensor = W*H*C/LANES. m_last is asserted while the counters point at the final beat.
- Final beat handshake with s_valid=0: go to IDLE.
- s_ready = IDLE || (m_valid && m_ready && m_last). This is a combinational path from m_ready to s_ready.
- Back-to-back: if s_valid is high in the cycle the final beat handshakes, the new tensor and order are latched, counters are cleared, and the block stays in STREAM with no bubble.
- Stall: while m_valid && !m_ready, m_data, m_last and m_index hold stable.
- The buffer is written only on an input handshake. The s_data content is ignored at all other times.
- Reset at any time, including mid-stream: the next cycle is in IDLE, and the partial tensor is discarded (its remaining beats are never emitted).

## Timing
- Reset values: m_valid=0, m_last=0, m_index=0, m_data=0, s_ready=1 (state IDLE).
- Latency: input handshake at edge N → first beat valid in the cycle after N.
- Throughput: one beat per cycle with m_ready held high. The tensor period is W*H*C/LANES cycles, plus 1 idle cycle if the next tensor does not arrive back-to-back.
- All outputs except s_ready are registered.

## Test plan
- Setup for all cases: defaults, every element value = its storage index e. Order 0, m_ready=1, tensor accepted at cycle 0.
  - Beats in cycles 1–48 carry values 0..47, m_index = 0..47.
  - m_last is high only on value 47.
  - s_ready is low in cycles 1–47 and high in cycle 48.
- Order 1, same tensor:
  - Beat sequence starts 0,3,6,9,12,15,18,21,24,27,30,33,36,39,42,45, then 1,4,…
  - Beat 47 = 47 with m_last; m_index increments 0..47.
- Order 0 with m_ready driven by a random 50% pattern:
  - 48 beats total, values 0..47 in order.
  - m_data, m_index and m_last are unchanged on every stalled cycle.
- Back-to-back: second tensor (values e+100) held with s_valid=1 from cycle 10.
  - It is accepted in cycle 48, the final beat of the first tensor.
  - Cycle 49 carries value 100, m_index=0; no idle cycle.
- rst pulsed at the cycle of beat 20:
  - The next cycle shows m_valid=0, s_ready=1, m_last=0.
  - A new tensor then restarts from value 0, m_index 0.
- LANES=2, HEIGHT=4, CHANNEL=2, WIDTH=2:
  - Order 0: beat 0 = {e1,e0}, 8 beats, last = {15,14}.
  - Order 1: beat 0 = {e2,e0}, beat 4 = {e3,e1}.
